// File: rtl/stb_hit_counter.sv
// Strobe-driven hit counter: requests N strobes from the strobe generator and counts how many
// of them see the synchronised comparator output high at the strobe rising edge.
module stb_hit_counter #(
    parameter int CNT_WIDTH   = 16,
    parameter int T_CNT_WIDTH = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [CNT_WIDTH-1:0]   num_samples_i,
    input  logic                   gen_rdy_i,
    input  logic [T_CNT_WIDTH-1:0] stb_period_i,
    input  logic                   stb_i,
    input  logic                   stb_valid_i,
    output logic                   stb_req_o,
    input  logic                   cmp_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [CNT_WIDTH-1:0]   hit_cnt_o
);

    localparam int TO_W  = T_CNT_WIDTH + 2;
    // The timer must be able to reach the 2^20 fallback limit used when the period is unknown.
    localparam int TMR_W = (TO_W > 21) ? TO_W : 21;

    typedef enum logic [2:0] {
        IDLE, WAIT_RDY, REQ, WAIT_CLR, WAIT_VALID, ACCUM, FINISH
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] cmp_sync_q, cmp_sync_d;
    logic                   stb_d_q, start_d_q;
    logic                   sample_q, sample_d;
    logic                   edge_seen_q, edge_seen_d;
    logic [CNT_WIDTH-1:0]   n_q, n_d;
    logic [CNT_WIDTH-1:0]   smp_cnt_q, smp_cnt_d;
    logic [CNT_WIDTH-1:0]   hit_cnt_q, hit_cnt_d;
    logic [TO_W-1:0]        to_q, to_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic                   err_q, err_d;

    logic                   cmp_s, stb_rise, start_rise, timed_out;
    logic [TMR_W-1:0]       tmr_inc, tmr_limit;
    logic [CNT_WIDTH-1:0]   smp_inc;

    assign cmp_s      = cmp_sync_q[SYNC_STAGES-1];
    assign stb_rise   = stb_i & ~stb_d_q;
    assign start_rise = start_i & ~start_d_q;
    assign tmr_inc    = tmr_q + 1'b1;
    assign tmr_limit  = (to_q == '0) ? (TMR_W'(1) << 20) : TMR_W'(to_q);
    assign timed_out  = (tmr_inc >= tmr_limit);
    assign smp_inc    = smp_cnt_q + 1'b1;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d     = state_q;
        n_d         = n_q;
        to_d        = to_q;
        tmr_d       = tmr_q;
        smp_cnt_d   = smp_cnt_q;
        hit_cnt_d   = hit_cnt_q;
        err_d       = err_q;
        sample_d    = stb_rise ? cmp_s : sample_q;
        edge_seen_d = edge_seen_q | stb_rise;
        cmp_sync_d  = {cmp_sync_q[SYNC_STAGES-1:0]};
        cmp_sync_d[0] = cmp_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            cmp_sync_d[i] = cmp_sync_q[i-1];
        end

        if (abort_i && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_rise) begin
                        n_d       = num_samples_i;
                        to_d      = {stb_period_i, 2'b00};
                        tmr_d     = '0;
                        smp_cnt_d = '0;
                        hit_cnt_d = '0;
                        err_d     = 1'b0;
                        state_d   = (num_samples_i == '0) ? FINISH : WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    tmr_d = tmr_inc;
                    if (timed_out) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else if (gen_rdy_i) begin
                        state_d = REQ;
                    end
                end
                REQ: begin
                    // A rise in the request cycle itself already belongs to this sample.
                    edge_seen_d = stb_rise;
                    tmr_d       = '0;
                    state_d     = WAIT_CLR;
                end
                WAIT_CLR, WAIT_VALID: begin
                    tmr_d = tmr_inc;
                    if (timed_out) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else if (state_q == WAIT_CLR && !stb_valid_i) begin
                        state_d = WAIT_VALID;
                    end else if (state_q == WAIT_VALID && stb_valid_i) begin
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (!edge_seen_q) begin
                        err_d = 1'b1;
                    end else if (sample_q && hit_cnt_q != '1) begin
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    end
                    smp_cnt_d = smp_inc;
                    state_d   = (smp_inc == n_q) ? FINISH : REQ;
                end
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q     <= IDLE;
            cmp_sync_q  <= '0;
            stb_d_q     <= 1'b0;
            start_d_q   <= 1'b0;
            sample_q    <= 1'b0;
            edge_seen_q <= 1'b0;
            n_q         <= '0;
            smp_cnt_q   <= '0;
            hit_cnt_q   <= '0;
            to_q        <= '0;
            tmr_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cmp_sync_q  <= cmp_sync_d;
            stb_d_q     <= stb_i;
            start_d_q   <= start_i;
            sample_q    <= sample_d;
            edge_seen_q <= edge_seen_d;
            n_q         <= n_d;
            smp_cnt_q   <= smp_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            to_q        <= to_d;
            tmr_q       <= tmr_d;
            err_q       <= err_d;
        end
    end

    assign stb_req_o = (state_q == REQ);
    assign done_o    = (state_q == FINISH);
    assign busy_o    = (state_q != IDLE);
    assign err_o     = err_q;
    assign hit_cnt_o = hit_cnt_q;

endmodule
